// File: rtl/osc_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osc_mon_pkg
//  Description : Shared state encoding and default widths for the
//                multi-channel oscillator frequency monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package osc_mon_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } mon_state_e;

  // Default configuration
  localparam int c_N_CH_DEF        = 4;
  localparam int c_CNT_W_DEF       = 16;
  localparam int c_WIN_W_DEF       = 20;
  localparam int c_SYNC_STAGES_DEF = 2;

endpackage : osc_mon_pkg
`default_nettype wire

// File: rtl/osc_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : osc_edge_sync
//  Description : One oscillator channel: multi-flop synchroniser into clk,
//                rising-edge detector and gated pass-through output.
//                SYNC_STAGES must be >= 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_raw_i,
  input  logic en_i,
  output logic edge_o,
  output logic osc_out_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_raw_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge seen on the synchronised copy; aliases above clk/2
  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Pure combinational gate on the raw oscillator; this path must stay off
  // the clock tree and is never retimed
  assign osc_out_o = osc_raw_i & en_i;

endmodule : osc_edge_sync
`default_nettype wire

// File: rtl/osc_freq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : osc_freq_monitor
//  Description : N-channel ring-oscillator gate and frequency monitor.
//                Counts synchronised rising edges per channel over a
//                programmable window of clk cycles and publishes the counts
//                with a one-cycle done pulse.
//                Optional macro OSC_FREQ_MONITOR_CONT_EN adds a 'cont' input
//                for back-to-back continuous windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_freq_monitor
  import osc_mon_pkg::*;
#(
  parameter int N_CH        = c_N_CH_DEF,
  parameter int CNT_W       = c_CNT_W_DEF,
  parameter int WIN_W       = c_WIN_W_DEF,
  parameter int SYNC_STAGES = c_SYNC_STAGES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        osc_raw,
  input  logic [N_CH-1:0]        osc_en,
  output logic [N_CH-1:0]        osc_out,
  input  logic                   start,
  input  logic [WIN_W-1:0]       win_cycles,
`ifdef OSC_FREQ_MONITOR_CONT_EN
  input  logic                   cont,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [N_CH*CNT_W-1:0]  count,
  output logic [N_CH-1:0]        ovf
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] c_WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  mon_state_e                   state_q, state_d;
  logic [N_CH-1:0]              en_q;
  logic [N_CH-1:0]              edge_w;
  logic [WIN_W-1:0]             win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0]             win_load;
  logic [N_CH-1:0][CNT_W-1:0]   work_q, work_d;
  logic [N_CH-1:0]              wovf_q, wovf_d;
  logic [N_CH*CNT_W-1:0]        count_q, count_d;
  logic [N_CH-1:0]              ovf_q, ovf_d;
  logic                         cont_w;

`ifdef OSC_FREQ_MONITOR_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif

  // A zero-length window is stretched to a single cycle
  assign win_load = (win_cycles == '0) ? c_WIN_ONE : win_cycles;

  // Per-channel synchroniser, edge detector and output gate
  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      osc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .osc_raw_i (osc_raw[g]),
        .en_i      (en_q[g]),
        .edge_o    (edge_w[g]),
        .osc_out_o (osc_out[g])
      );
    end
  endgenerate

  // Next-state, window, working-counter and result logic
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    work_d    = work_q;
    wovf_d    = wovf_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          win_cnt_d = win_load;
          work_d    = '0;
          wovf_d    = '0;
          state_d   = COUNT;
        end
      end

      COUNT: begin
        busy = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          if (en_q[i] && edge_w[i]) begin
            if (work_q[i] == c_CNT_MAX) begin
              wovf_d[i] = 1'b1;
            end else begin
              work_d[i] = work_q[i] + CNT_W'(1);
            end
          end
        end
        win_cnt_d = win_cnt_q - c_WIN_ONE;
        if (win_cnt_q == c_WIN_ONE) begin
          // Results are latched on entry to DONE (including this last
          // cycle's edges) so they are already valid while done is high
          count_d = work_d;
          ovf_d   = wovf_d;
          state_d = DONE;
        end
      end

      DONE: begin
        done = 1'b1;
        if (cont_w) begin
          win_cnt_d = win_load;
          work_d    = '0;
          wovf_d    = '0;
          state_d   = COUNT;
        end else begin
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, enable and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= '0;
      win_cnt_q <= '0;
      work_q    <= '0;
      wovf_q    <= '0;
      count_q   <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= osc_en;
      win_cnt_q <= win_cnt_d;
      work_q    <= work_d;
      wovf_q    <= wovf_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule : osc_freq_monitor
`default_nettype wire

// File: tb/tb_osc_freq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osc_freq_monitor
//  Description : Self-checking bench for osc_freq_monitor. Two instances are
//                driven in parallel: 16-bit counters and 4-bit counters (for
//                saturation). Expected results are queued at stimulus time.
//                OSC_FREQ_MONITOR_CONT_EN enables the continuous-mode steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osc_freq_monitor;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  osc_en = 4'h0;
  logic [19:0] win_cycles = '0;
  wire  [3:0]  osc_raw;
`ifdef OSC_FREQ_MONITOR_CONT_EN
  logic        cont = 1'b0;
`endif

  logic [3:0]  osc_out, s_osc_out;
  logic        busy, done, s_busy, s_done;
  logic [63:0] count;
  logic [15:0] s_count;
  logic [3:0]  ovf, s_ovf;

  // Oscillator half periods in ns (clk period is 10 ns)
  int half_ns[4] = '{50, 100, 200, 400};

  always #5 clk = ~clk;

  // Oscillators toggle 3 ns past a 10 ns grid, clear of clk edges
  generate
    for (genvar g = 0; g < 4; g++) begin : g_osc
      logic r = 1'b0;
      initial begin
        #3;
        forever begin
          #(half_ns[g]);
          r = ~r;
        end
      end
      assign osc_raw[g] = r;
    end
  endgenerate

  osc_freq_monitor #(
    .N_CH(4), .CNT_W(16), .WIN_W(20), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .osc_raw(osc_raw), .osc_en(osc_en),
    .osc_out(osc_out), .start(start), .win_cycles(win_cycles),
`ifdef OSC_FREQ_MONITOR_CONT_EN
    .cont(cont),
`endif
    .busy(busy), .done(done), .count(count), .ovf(ovf)
  );

  osc_freq_monitor #(
    .N_CH(4), .CNT_W(4), .WIN_W(20), .SYNC_STAGES(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .osc_raw(osc_raw), .osc_en(osc_en),
    .osc_out(s_osc_out), .start(start), .win_cycles(win_cycles),
`ifdef OSC_FREQ_MONITOR_CONT_EN
    .cont(cont),
`endif
    .busy(s_busy), .done(s_done), .count(s_count), .ovf(s_ovf)
  );

  int cyc      = 0;
  int done_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    string       tag;
    int          lat;
    logic [63:0] cnt;
    logic [3:0]  ovf;
    logic [15:0] scnt;
    logic [3:0]  sovf;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected edges = window / oscillator period (periods divide windows)
  task automatic push_exp(input string tag, input int w, input logic [3:0] en);
    exp_t e;
    int weff, per, n;
    weff   = (w == 0) ? 1 : w;
    e.tag  = tag;
    e.lat  = weff + 1;
    e.cnt  = '0;
    e.ovf  = '0;
    e.scnt = '0;
    e.sovf = '0;
    for (int i = 0; i < 4; i++) begin
      per = (2 * half_ns[i]) / 10;
      n   = en[i] ? (weff / per) : 0;
      e.cnt[i*16 +: 16] = 16'(n);
      e.scnt[i*4 +: 4]  = (n > 15) ? 4'hF : 4'(n);
      e.sovf[i]         = (n > 15);
    end
    sb.push_back(e);
  endtask

  // t0 is the cycle in which start is high
  task automatic kick(input int w, output int t0);
    @(posedge clk);
    #1;
    win_cycles = 20'(w);
    t0    = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, output int tdone);
    exp_t e;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 3000);
    tdone = cyc;
    e = sb.pop_front();
    chk({e.tag, " done"},    64'(done),    64'd1);
    chk({e.tag, " latency"}, 64'(cyc - t0), 64'(e.lat));
    chk({e.tag, " busy"},    64'(busy),    64'd0);
    chk({e.tag, " count"},   count,        e.cnt);
    chk({e.tag, " ovf"},     64'(ovf),     64'(e.ovf));
    chk({e.tag, " s_done"},  64'(s_done),  64'd1);
    chk({e.tag, " s_count"}, 64'(s_count), 64'(e.scnt));
    chk({e.tag, " s_ovf"},   64'(s_ovf),   64'(e.sovf));
    @(negedge clk);
    chk({e.tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int t0, td, dc0;

    // Reset with oscillators running and enables requested
    osc_en = 4'hF;
    repeat (5) @(negedge clk);
    chk("rst busy",    64'(busy),    64'd0);
    chk("rst done",    64'(done),    64'd0);
    chk("rst count",   count,        64'd0);
    chk("rst ovf",     64'(ovf),     64'd0);
    chk("rst osc_out", 64'(osc_out), 64'd0);
    chk("rst s_count", 64'(s_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel busy",  64'(busy), 64'd0);
    chk("rel done",  64'(done), 64'd0);
    chk("rel count", count,     64'd0);
    repeat (20) @(negedge clk);

    // Basic count, all channels
    push_exp("basic", 400, 4'hF);
    kick(400, t0);
    wait_done(t0, td);

    // Enable gating
    osc_en = 4'b0101;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("gate out1", 64'(osc_out[1]), 64'd0);
      chk("gate out3", 64'(osc_out[3]), 64'd0);
      chk("gate out0", 64'(osc_out[0]), 64'(osc_raw[0]));
      repeat (5) @(negedge clk);
    end
    push_exp("gate", 400, 4'b0101);
    kick(400, t0);
    wait_done(t0, td);

    // Saturation: period 4 clk on all channels
    half_ns = '{20, 20, 20, 20};
    repeat (100) @(negedge clk);
    push_exp("sat", 200, 4'b0101);
    kick(200, t0);
    wait_done(t0, td);

    // Zero-length window
    osc_en = 4'h0;
    repeat (3) @(negedge clk);
    push_exp("win0", 0, 4'h0);
    kick(0, t0);
    wait_done(t0, td);

    // Start while busy is ignored
    osc_en = 4'hF;
    repeat (3) @(negedge clk);
    dc0 = done_cnt;
    push_exp("busy_start", 60, 4'hF);
    kick(60, t0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(t0, td);
    repeat (100) @(negedge clk);
    chk("busy_start ndone", 64'(done_cnt - dc0), 64'd1);

    // Asynchronous reset in the middle of a window
    kick(100, t0);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy",  64'(busy), 64'd0);
    chk("arst done",  64'(done), 64'd0);
    chk("arst count", count,     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (150) @(negedge clk);
    chk("arst ndone", 64'(done_cnt - dc0), 64'd0);
    chk("arst count_after", count, 64'd0);
    chk("arst busy_after", 64'(busy), 64'd0);

`ifdef OSC_FREQ_MONITOR_CONT_EN
    // Continuous windows, then drop cont for one last window
    half_ns = '{50, 100, 250, 500};
    repeat (200) @(negedge clk);
    cont = 1'b1;
    push_exp("cont1", 100, 4'hF);
    push_exp("cont2", 100, 4'hF);
    push_exp("cont3", 100, 4'hF);
    kick(100, t0);
    wait_done(t0, td);
    wait_done(td, td);
    repeat (10) @(negedge clk);
    cont = 1'b0;
    dc0 = done_cnt;
    wait_done(td, td);
    repeat (300) @(negedge clk);
    chk("cont ndone", 64'(done_cnt - dc0), 64'd1);
    chk("cont idle",  64'(busy),           64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_osc_freq_monitor
`default_nettype wire
